// File: rtl/mult_issue_ctrl_pkg.sv
// Shared types for the multiply issue controller and its result queue.
package mult_issue_ctrl_pkg;

  localparam int unsigned DataW      = 32;
  localparam int unsigned MultTagW   = 6;
  // Pipeline depth of the multiplier datapath; issue logic must agree with it.
  localparam int unsigned MultStages = 4;

  typedef logic [DataW-1:0] data_t;

  typedef enum logic [1:0] {
    M_MUL    = 2'd0,
    M_MULH   = 2'd1,
    M_MULHSU = 2'd2,
    M_MULHU  = 2'd3
  } mult_func_t;

  typedef struct packed {
    data_t                result;
    logic [MultTagW-1:0]  tag;
  } mult_result_t;

endpackage

// File: rtl/mult_result_fifo.sv
// Circular FIFO holding finished multiply results until the CDB takes them.
module mult_result_fifo #(
  parameter  int unsigned Depth = 4,
  parameter  int unsigned Width = 38,
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic            pop_i,
  output logic [Width-1:0] rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Next-state: pop only when non-empty; a push at full is legal only alongside a pop.
  always_comb begin
    do_pop  = pop_i & (cnt_q != '0);
    do_push = push_i & ((cnt_q != CntW'(Depth)) | do_pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = next_ptr(wptr_q);
      end
      if (do_pop) begin
        rptr_d = next_ptr(rptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers; storage is cleared too so the head output is never X.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Status and head outputs.
  always_comb begin
    rdata_o = mem_q[rptr_q];
    full_o  = (cnt_q == CntW'(Depth));
    empty_o = (cnt_q == '0);
    count_o = cnt_q;
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Round-robin issue of requester ops into a shared fixed-latency multiplier,
// with tags tracked alongside the pipe and results buffered for the CDB.
module mult_issue_ctrl
  import mult_issue_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned LATENCY    = MultStages,
  parameter int unsigned OUTQ_DEPTH = 4,
  parameter int unsigned TAG_W      = MultTagW
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][DataW-1:0]   req_rs1,
  input  logic [NUM_REQ-1:0][DataW-1:0]   req_rs2,
  input  mult_func_t [NUM_REQ-1:0]        req_func,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
  output logic [NUM_REQ-1:0]              req_grant,
  output logic                            mult_start,
  output logic [DataW-1:0]                mult_rs1,
  output logic [DataW-1:0]                mult_rs2,
  output mult_func_t                      mult_func,
  input  logic [DataW-1:0]                mult_result,
  input  logic                            mult_done,
  input  logic                            flush,
  output logic                            cdb_valid,
  output logic [DataW-1:0]                cdb_result,
  output logic [TAG_W-1:0]                cdb_tag,
  input  logic                            cdb_ready,
  output logic                            busy
);

  localparam int unsigned PtrW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned QCntW = $clog2(OUTQ_DEPTH + 1);
  localparam int unsigned OccW  = $clog2(LATENCY + OUTQ_DEPTH + 1);
  localparam int unsigned WinW  = $clog2(LATENCY + 1);
  localparam int unsigned EntW  = DataW + TAG_W;

  logic [PtrW-1:0]               ptr_q, ptr_d;
  logic [LATENCY-1:0]            pipe_vld_q, pipe_vld_d;
  logic [LATENCY-1:0][TAG_W-1:0] pipe_tag_q, pipe_tag_d;
  logic [WinW-1:0]               win_q, win_d;
  logic [OccW-1:0]               occ;
  logic                          issue_ok;
  logic                          gnt_found;
  logic [PtrW-1:0]               gnt_idx;
  logic [PtrW-1:0]               cand;
  logic                          q_push, q_pop, q_full, q_empty;
  logic [QCntW-1:0]              q_cnt;
  logic [EntW-1:0]               q_wdata, q_rdata;

  // Credit: every op in the pipe already owns a queue slot; a same-cycle pop frees nothing.
  always_comb begin
    occ = OccW'(q_cnt);
    for (int i = 0; i < LATENCY; i++) begin
      occ = occ + OccW'(pipe_vld_q[i]);
    end
    issue_ok = (occ < OccW'(OUTQ_DEPTH)) && !flush && !reset;
    busy     = (occ != '0);
  end

  // Round-robin search starting at the pointer, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    req_grant = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PtrW'((32'(ptr_q) + k) % NUM_REQ);
      if (issue_ok && !gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (gnt_found) begin
      req_grant[gnt_idx] = 1'b1;
    end
  end

  // Multiplier issue mux; requester 0 is presented when idle.
  always_comb begin
    mult_start = gnt_found;
    mult_rs1   = req_rs1[gnt_idx];
    mult_rs2   = req_rs2[gnt_idx];
    mult_func  = req_func[gnt_idx];
  end

  // Next pointer, tag pipe shift and post-flush window for stray mult_done pulses.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_found) begin
      ptr_d = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + PtrW'(1);
    end
    pipe_vld_d    = '0;
    pipe_tag_d    = pipe_tag_q;
    pipe_vld_d[0] = gnt_found;
    pipe_tag_d[0] = req_tag[gnt_idx];
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1] & ~flush;
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
    if (flush) begin
      win_d = WinW'(LATENCY);
    end else if (win_q != '0) begin
      win_d = win_q - WinW'(1);
    end else begin
      win_d = win_q;
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q      <= '0;
      pipe_vld_q <= '0;
      pipe_tag_q <= '0;
      win_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_tag_q <= pipe_tag_d;
      win_q      <= win_d;
    end
  end

  // A done without a live tail belongs to a flushed op and is dropped here.
  always_comb begin
    q_push     = pipe_vld_q[LATENCY-1] & mult_done;
    q_wdata    = {mult_result, pipe_tag_q[LATENCY-1]};
    cdb_valid  = ~q_empty;
    q_pop      = cdb_valid & cdb_ready;
    cdb_result = q_rdata[EntW-1:TAG_W];
    cdb_tag    = q_rdata[TAG_W-1:0];
  end

  mult_result_fifo #(
    .Depth (OUTQ_DEPTH),
    .Width (EntW)
  ) u_outq (
    .clock   (clock),
    .reset   (reset),
    .clear_i (flush),
    .push_i  (q_push),
    .wdata_i (q_wdata),
    .pop_i   (q_pop),
    .rdata_o (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_cnt)
  );

  a_tail_matches_done: assert property (@(posedge clock) disable iff (reset)
    (win_q == '0) |-> (pipe_vld_q[LATENCY-1] == mult_done));

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    q_push |-> (!q_full || q_pop));

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Randomised scoreboard bench for mult_issue_ctrl with a behavioural multiplier stub.
module tb_mult_issue_ctrl;
  import mult_issue_ctrl_pkg::*;

  localparam int NR  = 2;
  localparam int LAT = 4;
  localparam int DEP = 4;
  localparam int TW  = 6;

  logic                   clock, reset, flush, cdb_ready, mult_done;
  logic [NR-1:0]          req_valid, req_grant;
  logic [NR-1:0][31:0]    req_rs1, req_rs2;
  mult_func_t [NR-1:0]    req_func;
  logic [NR-1:0][TW-1:0]  req_tag;
  logic                   mult_start, cdb_valid, busy;
  logic [31:0]            mult_rs1, mult_rs2, mult_result, cdb_result;
  mult_func_t             mult_func;
  logic [TW-1:0]          cdb_tag;

  typedef struct {
    logic [31:0]   res;
    logic [TW-1:0] tag;
    longint        ready;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     mptr = 0;
  int     dut_grants = 0;

  mult_issue_ctrl #(
    .NUM_REQ    (NR),
    .LATENCY    (LAT),
    .OUTQ_DEPTH (DEP),
    .TAG_W      (TW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_func    (req_func),
    .req_tag     (req_tag),
    .req_grant   (req_grant),
    .mult_start  (mult_start),
    .mult_rs1    (mult_rs1),
    .mult_rs2    (mult_rs2),
    .mult_func   (mult_func),
    .mult_result (mult_result),
    .mult_done   (mult_done),
    .flush       (flush),
    .cdb_valid   (cdb_valid),
    .cdb_result  (cdb_result),
    .cdb_tag     (cdb_tag),
    .cdb_ready   (cdb_ready),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] ref_mul(input mult_func_t f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      M_MUL:    begin p = sa * sb; return p[31:0];  end
      M_MULH:   begin p = sa * sb; return p[63:32]; end
      M_MULHSU: begin p = sa * ub; return p[63:32]; end
      default:  begin p = ua * ub; return p[63:32]; end
    endcase
  endfunction

  // Multiplier stub: fixed LAT-cycle pipe, reset with the DUT, blind to flush.
  logic [LAT-1:0] st_vld;
  logic [31:0]    st_res [LAT];
  always @(posedge clock) begin
    if (reset) begin
      st_vld <= '0;
    end else begin
      st_vld    <= {st_vld[LAT-2:0], mult_start};
      st_res[0] <= ref_mul(mult_func, mult_rs1, mult_rs2);
      for (int i = 1; i < LAT; i++) st_res[i] <= st_res[i-1];
    end
  end
  assign mult_done   = st_vld[LAT-1];
  assign mult_result = st_res[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: inputs were driven at posedge+1; compare issue-side outputs at posedge+4.
  task automatic step();
    int occ, gi, sel;
    #3;
    if (|req_grant) dut_grants++;
    if (reset) begin
      check("grant_in_reset", req_grant, 0);
      check("start_in_reset", mult_start, 0);
      mptr = 0;
    end else begin
      occ = exp_q.size();
      gi  = -1;
      if (!flush && occ < DEP) begin
        for (int k = 0; k < NR; k++) begin
          int c;
          c = (mptr + k) % NR;
          if (gi < 0 && req_valid[c]) gi = c;
        end
      end
      sel = (gi >= 0) ? gi : 0;
      check("busy", busy, occ != 0);
      check("grant", req_grant, (gi >= 0) ? (1 << gi) : 0);
      check("mult_start", mult_start, gi >= 0);
      check("mult_rs1", mult_rs1, req_rs1[sel]);
      check("mult_rs2", mult_rs2, req_rs2[sel]);
      check("mult_func", mult_func, req_func[sel]);
      if (gi >= 0) begin
        mptr = (gi + 1) % NR;
        exp_q.push_back('{ref_mul(req_func[sel], req_rs1[sel], req_rs2[sel]),
                          req_tag[sel], cyc + LAT + 1});
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: the queue head must appear exactly once its result is due, in issue order.
  always @(negedge clock) begin
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      check("cdb_valid", cdb_valid, (exp_q.size() != 0) && (cyc >= exp_q[0].ready));
      if (cdb_valid && exp_q.size() != 0 && cyc >= exp_q[0].ready) begin
        check("cdb_result", cdb_result, exp_q[0].res);
        check("cdb_tag", cdb_tag, exp_q[0].tag);
        if (cdb_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input mult_func_t f, input logic [TW-1:0] t);
    req_rs1[i]  = a;
    req_rs2[i]  = b;
    req_func[i] = f;
    req_tag[i]  = t;
  endtask

  task automatic drain();
    req_valid = '0;
    cdb_ready = 1'b1;
    for (int i = 0; i < 40 && (busy || cdb_valid); i++) step();
    check("drained", busy, 0);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom_range(0, 15);
      default: return 32'h8000_0000;
    endcase
  endfunction

  initial begin
    int base;
    req_valid = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    req_func  = {M_MUL, M_MUL};
    req_tag   = '0;
    cdb_ready = 1'b1;
    flush     = 1'b0;
    reset     = 1'b1;
    @(posedge clock);
    #1;
    step();
    step();
    reset = 1'b0;
    check("cdb_valid_after_reset", cdb_valid, 0);
    check("busy_after_reset", busy, 0);

    // Single op: grant, then the result reaches the CDB LAT+1 cycles later.
    set_req(0, 7, 6, M_MUL, 5);
    req_valid = 2'b01;
    step();
    req_valid = '0;
    repeat (LAT) step();
    check("single_valid", cdb_valid, 1);
    check("single_result", cdb_result, 42);
    check("single_tag", cdb_tag, 5);
    step();

    // High-half variants on back-to-back cycles from alternating requesters.
    set_req(0, 32'hFFFF_FFFF, 2, M_MULH, 9);
    set_req(1, 32'hFFFF_FFFF, 2, M_MULHU, 10);
    req_valid = 2'b01;
    step();
    req_valid = 2'b10;
    step();
    req_valid = '0;
    repeat (LAT - 1) step();
    check("mulh_result", cdb_result, 32'hFFFF_FFFF);
    check("mulh_tag", cdb_tag, 9);
    step();
    check("mulhu_result", cdb_result, 32'h0000_0001);
    check("mulhu_tag", cdb_tag, 10);
    drain();

    // Round-robin with both requesters always ready.
    for (int i = 0; i < 20; i++) begin
      set_req(0, i, 3, M_MUL, TW'(i));
      set_req(1, i, 5, M_MUL, TW'(i + 32));
      req_valid = 2'b11;
      step();
    end
    drain();

    // Backpressure: only the credit limit's worth of ops may be granted.
    cdb_ready = 1'b0;
    req_valid = 2'b11;
    base = dut_grants;
    for (int i = 0; i < 10; i++) begin
      set_req(i % 2, $urandom, $urandom, M_MUL, TW'(i));
      step();
    end
    check("bp_grants", dut_grants - base, 4);
    check("bp_busy", busy, 1);
    check("bp_cdb_valid", cdb_valid, 1);
    cdb_ready = 1'b1;
    for (int i = 0; i < 30 && (dut_grants - base) < 6; i++) step();
    check("bp_total_grants", dut_grants - base, 6);
    drain();

    // Flush: three ops squashed, the op granted right after returns normally.
    for (int i = 0; i < 3; i++) begin
      set_req(0, 11 + i, 2, M_MUL, TW'(20 + i));
      req_valid = 2'b01;
      step();
    end
    req_valid = '0;
    step();
    flush = 1'b1;
    set_req(0, 1, 1, M_MUL, 23);
    req_valid = 2'b01;
    step();
    flush = 1'b0;
    check("flush_cdb_valid", cdb_valid, 0);
    check("flush_busy", busy, 0);
    set_req(0, 3, 5, M_MUL, 24);
    step();
    req_valid = '0;
    repeat (LAT) step();
    check("post_flush_result", cdb_result, 15);
    check("post_flush_tag", cdb_tag, 24);
    drain();

    // Reset with ops both in flight and queued.
    cdb_ready = 1'b0;
    req_valid = 2'b11;
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_cdb_valid", cdb_valid, 0);
    check("rst_mid_busy", busy, 0);
    cdb_ready = 1'b1;
    req_valid = 2'b11;
    step();
    drain();

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 4000; i++) begin
      for (int r = 0; r < NR; r++) begin
        set_req(r, rand_op(), rand_op(), mult_func_t'($urandom_range(0, 3)),
                TW'($urandom));
      end
      req_valid = NR'($urandom);
      cdb_ready = ($urandom_range(0, 3) != 0) ^ (i[9]);
      flush     = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      step();
    end
    flush = 1'b0;
    reset = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
- Shares one pipelined multiplier among NUM_REQ multiply reservation-station requesters.
- Arbitrates round-robin and issues at most one op per cycle.
- Carries each op's destination tag alongside the fixed-latency multiplier pipeline.
- Buffers finished results in an output queue for the CDB, so the non-stallable multiplier never loses a result.
- Sits between the RS multiply entries, the mult datapath and the CDB arbiter.

Parameters:
- NUM_REQ, 2, number of requesters.
- LATENCY, `MULT_STAGES (default 4), cycles from mult_start to mult_done; must match the multiplier.
- OUTQ_DEPTH, 4, result queue entries; must be ≥ 1.
- TAG_W, 6, destination tag width.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  requester i has a ready op.
- req_rs1  in  NUM_REQ x 32  operand 1 per requester.
- req_rs2  in  NUM_REQ x 32  operand 2 per requester.
- req_func  in  NUM_REQ x MULT_FUNC  op per requester.
- req_tag  in  NUM_REQ x TAG_W  destination tag per requester.
- req_grant  out  NUM_REQ  one-hot accept; the op is consumed this cycle.
- mult_start  out  1  issue pulse to the multiplier.
- mult_rs1  out  32  muxed operand 1.
- mult_rs2  out  32  muxed operand 2.
- mult_func  out  MULT_FUNC  muxed func.
- mult_result  in  32  multiplier result.
- mult_done  in  1  multiplier result valid.
- flush  in  1  squash all in-flight and queued ops.
- cdb_valid  out  1  queue head valid.
- cdb_result  out  32  queue head result.
- cdb_tag  out  TAG_W  queue head tag.
- cdb_ready  in  1  CDB accepts the head this cycle.
- busy  out  1  any op in flight or queued.

Behaviour:
- Reset values:
  - req_grant = 0, mult_start = 0, cdb_valid = 0, busy = 0.
  - Round-robin pointer = 0; tag pipe valids = 0; queue empty.
  - mult_rs1/rs2/func/cdb_result/cdb_tag are don't-care under reset but must be driven (no X).
- Credit:
  - occupancy = (valid entries in tag pipe) + (queue count), using registered state.
  - Issue is allowed iff occupancy < OUTQ_DEPTH and flush = 0.
  - A same-cycle CDB pop does not add credit.
- Arbitration (combinational, same cycle):
  - Search from the pointer upward, wrapping; grant the first requester with req_valid = 1.
  - On a grant to i, pointer ← (i+1) mod NUM_REQ; otherwise the pointer holds.
  - mult_start = |req_grant. mult_rs1/rs2/func are the granted requester's operands; requester 0's when there is no grant.
- Tag pipe:
  - LATENCY-deep shift register of {valid, tag}.
  - Stage 0 is loaded with {mult_start, granted tag} each cycle; it shifts every cycle.
  - At the tail, tail.valid must equal mult_done (assertion, except cycles following a flush).
  - When tail.valid & mult_done: push {mult_result, tail.tag} into the queue.
  - mult_done with tail.valid = 0 means the result of a flushed op; discard it.
- Latency:
  - A grant in cycle T gives mult_done in T+LATENCY.
  - The queue push is registered, so cdb_valid rises at T+LATENCY+1 when the queue was empty.
  - Grant-to-CDB latency is therefore LATENCY+1.
- Queue:
  - FIFO with wrap-around head/tail pointers.
  - Pop when cdb_valid & cdb_ready.
  - Simultaneous push and pop are allowed at any count, including full (the credit rule guarantees a push never overflows).
  - Push and pop together when empty with cdb_valid = 0: push only.
  - cdb_* outputs hold stable while cdb_valid & !cdb_ready.
- Flush:
  - Same cycle: no grant and no mult_start; pointer unchanged.
  - Next cycle: all tag-pipe valids = 0, queue empty, cdb_valid = 0.
  - mult_done pulses from flushed ops arriving over the next LATENCY cycles are dropped.
  - Ops granted in the cycle after a flush proceed normally.
- Reset mid-operation: same end state as reset; the multiplier is reset by the same signal.
- busy = occupancy != 0.

Decomposition:
- Shared package (alongside MULT_FUNC and DATA): the MULT_RESULT struct {DATA result; logic [TAG_W-1:0] tag}, with TAG_W as a package constant.
- Natural sub-module: mult_result_fifo, a parameterised depth/width FIFO with push, pop, full, empty and count.
- Arbiter and tag pipe stay inline.

Test Plan:
- Single op, LATENCY=4: req 0 with rs1=7, rs2=6, M_MUL, tag=5 in cycle 2 → grant[0] in cycle 2; mult_done in cycle 6; cdb_valid with result 42, tag 5 in cycle 7.
- Round-robin: both requesters valid every cycle, cdb_ready=1 → grants alternate 0,1,0,1. With OUTQ_DEPTH=4 the stream stalls once 4 are in flight; no grant appears while occupancy = 4.
- Backpressure: cdb_ready=0, issue 6 ops → exactly 4 grants, queue full, busy=1. Raise cdb_ready → results pop in issue order with their correct tags, followed by the remaining 2 grants.
- Flush: issue 3 ops, assert flush 2 cycles later → no cdb_valid for the flushed tags. A new op granted the cycle after the flush returns its correct result at the expected latency.
- Functional mix: M_MULH with rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF. M_MULHU with the same operands → 0x00000001. Tags are preserved.
- Reset mid-stream: reset with 2 in flight and 2 queued → next cycle cdb_valid=0, busy=0, pointer=0; the first request after reset is granted to requester 0.
